// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [SEL_W-1:0]  r0_sel,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [SEL_W-1:0]  r1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_d,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_ovf,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_d,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic              busy,
  output logic              grant_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       gnt0_cnt,
  output logic [15:0]       gnt1_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state;
  logic                ptr;
  logic                pick;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic [SEL_W-1:0]    sel_p0;
  logic [DATA_W-1:0]   d_p1;
  logic                zero_p1;
  logic                carry_p1;
  logic                ovf_p1;
  logic                rsp_taken;

  // Sole valid requester wins; on contention the pointer decides.
  always_comb begin
    pick = ptr;
    if (r0_valid && !r1_valid)
      pick = 1'b0;
    else if (r1_valid && !r0_valid)
      pick = 1'b1;
  end

  assign r0_ready  = (state == IDLE) && r0_valid && !pick;
  assign r1_ready  = (state == IDLE) && r1_valid && pick;
  assign rsp_taken = grant_id ? rsp1_ready : rsp0_ready;

  assign alu_a     = a_p0;
  assign alu_b     = b_p0;
  assign alu_sel   = sel_p0;
  assign rsp_d     = d_p1;
  assign rsp_zero  = zero_p1;
  assign rsp_carry = carry_p1;
  assign rsp_ovf   = ovf_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      a_p0       <= '0;
      b_p0       <= '0;
      sel_p0     <= '0;
      d_p1       <= '0;
      zero_p1    <= 1'b0;
      carry_p1   <= 1'b0;
      ovf_p1     <= 1'b0;
    end else begin
      case (state)
        // p0: latch the winner's operands
        IDLE: begin
          if (r0_ready || r1_ready) begin
            a_p0     <= pick ? r1_a   : r0_a;
            b_p0     <= pick ? r1_b   : r0_b;
            sel_p0   <= pick ? r1_sel : r0_sel;
            grant_id <= pick;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        // p1: capture ALU result and flags
        ISSUE: begin
          d_p1       <= alu_d;
          zero_p1    <= alu_zero;
          carry_p1   <= alu_carry;
          ovf_p1     <= alu_ovf;
          rsp0_valid <= !grant_id;
          rsp1_valid <= grant_id;
          state      <= RESP;
        end
        // p2: hold response until the owning requester takes it
        RESP: begin
          if (rsp_taken) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            ptr        <= ~grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (r0_ready) gnt0_cnt <= sat_inc(gnt0_cnt);
      if (r1_ready) gnt1_cnt <= sat_inc(gnt1_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter with a small behavioural ALU.
module tb_alu_share_arbiter;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_valid, r0_ready, r1_valid, r1_ready;
  logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [SEL_W-1:0]  r0_sel, r1_sel;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_d;
  logic              rsp_zero, rsp_carry, rsp_ovf;
  logic [DATA_W-1:0] alu_a, alu_b, alu_d;
  logic [SEL_W-1:0]  alu_sel;
  logic              alu_zero, alu_carry, alu_ovf;
  logic              busy, grant_id;

  int n_cmp = 0;
  int n_err = 0;

  alu_share_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_d(rsp_d), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_d(alu_d), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 = ADD, 1 = SUB, anything else = XOR.
  logic [DATA_W:0] sum;
  always_comb begin
    sum       = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    case (alu_sel)
      4'd0: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = sum[DATA_W];
        alu_ovf   = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (sum[DATA_W-1] != alu_a[DATA_W-1]);
      end
      4'd1: begin
        sum       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_carry = sum[DATA_W];
        alu_ovf   = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (sum[DATA_W-1] != alu_a[DATA_W-1]);
      end
      default: sum = {1'b0, alu_a ^ alu_b};
    endcase
    alu_d    = sum[DATA_W-1:0];
    alu_zero = (alu_d == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  int waited;

  initial begin
    rst = 1'b1;
    r0_valid = 0; r1_valid = 0; r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
    r0_sel = 0; r1_sel = 0; rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) tick();
    rst = 1'b0;
    samp();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rsp0v", rsp0_valid, 0);
    chk("rst_rsp1v", rsp1_valid, 0);
    chk("rst_rsp_d", rsp_d, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_r0rdy", r0_ready, 0);

    // Single r0 ADD 6 + 7
    tick();
    r0_valid = 1; r0_a = 32'h6; r0_b = 32'h7; r0_sel = 4'd0;
    samp();
    chk("t1_r0rdy", r0_ready, 1);
    chk("t1_r1rdy", r1_ready, 0);
    tick();
    r0_valid = 0;
    samp();
    chk("t1_busy", busy, 1);
    chk("t1_rsp0v_n1", rsp0_valid, 0);
    chk("t1_alu_a", alu_a, 32'h6);
    chk("t1_alu_b", alu_b, 32'h7);
    tick();
    samp();
    chk("t1_rsp0v_n2", rsp0_valid, 1);
    chk("t1_rsp1v", rsp1_valid, 0);
    chk("t1_d", rsp_d, 32'hD);
    chk("t1_flags", {rsp_zero, rsp_carry, rsp_ovf}, 3'b000);
    tick();
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    samp();
    chk("t1_done_v", rsp0_valid, 0);
    chk("t1_done_busy", busy, 0);

    // Simultaneous requests after reset: r0 SUB first, then r1 ADD overflow
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    r0_valid = 1; r0_a = 32'h5; r0_b = 32'h5; r0_sel = 4'd1;
    r1_valid = 1; r1_a = 32'h7FFFFFFF; r1_b = 32'h1; r1_sel = 4'd0;
    rsp0_ready = 1; rsp1_ready = 1;
    samp();
    chk("t2_r0rdy", r0_ready, 1);
    chk("t2_r1rdy", r1_ready, 0);
    tick();
    r0_valid = 0;
    samp();
    chk("t2_r1wait", r1_ready, 0);
    chk("t2_gnt0", grant_id, 0);
    tick();
    samp();
    chk("t2_rsp0v", rsp0_valid, 1);
    chk("t2_d0", rsp_d, 32'h0);
    chk("t2_zero", rsp_zero, 1);
    tick();
    samp();
    chk("t2_r1rdy2", r1_ready, 1);
    tick();
    r1_valid = 0;
    samp();
    chk("t2_gnt1", grant_id, 1);
    tick();
    samp();
    chk("t2_rsp1v", rsp1_valid, 1);
    chk("t2_rsp0v_lo", rsp0_valid, 0);
    chk("t2_d1", rsp_d, 32'h80000000);
    chk("t2_flags", {rsp_zero, rsp_carry, rsp_ovf}, 3'b001);
    tick();

    // Both held valid: grants alternate, two idle cycles between grants
    r0_valid = 1; r0_a = 32'h1; r0_b = 32'h2; r0_sel = 4'd0;
    r1_valid = 1; r1_a = 32'h3; r1_b = 32'h4; r1_sel = 4'd2;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      samp();
      while (!(r0_ready || r1_ready) && waited < 10) begin
        tick();
        waited++;
        samp();
      end
      if (waited >= 10) chk("alt_timeout", 0, 1);
      chk("alt_r0", r0_ready, (k % 2 == 0) ? 1 : 0);
      chk("alt_r1", r1_ready, (k % 2 == 1) ? 1 : 0);
      chk("alt_wait", waited, (k == 0) ? 0 : 2);
      tick();
    end
    r0_valid = 0; r1_valid = 0;
    tick();
    tick();

    // Response stall on requester 0 while r1 waits
    rsp0_ready = 0;
    r0_valid = 1; r0_a = 32'h10; r0_b = 32'h20; r0_sel = 4'd0;
    r1_valid = 1; r1_a = 32'h1; r1_b = 32'h1; r1_sel = 4'd0;
    samp();
    chk("t4_r0rdy", r0_ready, 1);
    tick();
    r0_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      samp();
      chk("t4_rsp0v", rsp0_valid, 1);
      chk("t4_d", rsp_d, 32'h30);
      chk("t4_r1rdy", r1_ready, 0);
      tick();
    end
    rsp0_ready = 1;
    samp();
    chk("t4_hold", rsp0_valid, 1);
    tick();
    rsp0_ready = 0;
    samp();
    chk("t4_rel_v", rsp0_valid, 0);
    chk("t4_r1go", r1_ready, 1);
    tick();
    r1_valid = 0;
    tick();
    tick();

    // Reset during ISSUE with pointer favouring r1 beforehand
    rsp0_ready = 1;
    r0_valid = 1; r0_a = 32'h1; r0_b = 32'h2; r0_sel = 4'd0;
    tick();
    r0_valid = 0;
    tick();
    tick();
    r0_valid = 1; r0_a = 32'h3; r0_b = 32'h4;
    tick();
    r0_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_rsp0v", rsp0_valid, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_rsp_d", rsp_d, 0);
    tick();
    rst = 1'b0;
    r0_valid = 1; r1_valid = 1;
    samp();
    chk("t5_r0first", r0_ready, 1);
    chk("t5_r1wait", r1_ready, 0);
    tick();
    r0_valid = 0; r1_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
